uart_rx_frame: RTL

//  Serial receiver for the 10-bit UART frame produced by the team's transmitter.

---
 rtl/uart_rx_frame.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with a 2-flop synchronizer, mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN to take each bit from a 2-of-3 vote around mid-bit.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 22
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       Din,
  output logic [7:0] dataout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = MID + 1;
`else
  localparam int SAMP = MID;
`endif
  localparam logic [CW-1:0] START_AT = CW'(SAMP);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] ARM   = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  logic [1:0]    sync_q, sync_d, hist_q, hist_d;
  logic [2:0]    state_q, state_d, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d, dataout_q, dataout_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;
  logic          rxd, bit_val;
  assign rxd = sync_q[1];
  // hist_q holds the two previous rxd values, so the vote spans three consecutive cycles
`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd) | (hist_q[0] & rxd);
`else
  assign bit_val = rxd;
`endif
  always_comb begin
    sync_d    = {sync_q[0], Din};
    hist_d    = {hist_q[0], rxd};
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    shift_d   = shift_q;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
    if (!enable) begin
      state_d = ARM;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ARM: state_d = rxd ? IDLE : ARM;
        IDLE: if (!rxd) begin
          state_d = START;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
        START: if (cnt_q == START_AT) begin
          state_d = bit_val ? IDLE : DATA;
          busy_d  = !bit_val;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
        DATA: if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_val;
          idx_d          = idx_q + 3'd1;
          state_d        = (idx_q == 3'd7) ? STOP : DATA;
        end
        STOP: if (cnt_q == LAST) begin
          // leave mid-stop-bit so a start edge right after the stop bit is caught
          busy_d    = 1'b0;
          valid_d   = bit_val;
          ferr_d    = !bit_val;
          dataout_d = bit_val ? shift_q : dataout_q;
          state_d   = bit_val ? IDLE : ARM;
        end
        default: state_d = ARM;
      endcase
    end
  end
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      hist_q    <= 2'b11;
      state_q   <= ARM;
      idx_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end
  assign dataout   = dataout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
endmodule
